// File: rtl/uart_led_cmd_if.sv
// rtl/uart_led_cmd_if.sv - RX/TX FIFO handshake bundle between the UART top and the LED command consumer
interface uart_led_cmd_if #(
  parameter int DBITS = 8
);
  logic             rx_empty;
  logic [DBITS-1:0] read_data;
  logic             read_uart;
  logic             tx_full;
  logic             write_uart;
  logic [DBITS-1:0] write_data;

  // Command consumer side: reads the RX FIFO, writes the TX FIFO
  modport master (
    input  rx_empty,
    input  read_data,
    input  tx_full,
    output read_uart,
    output write_uart,
    output write_data
  );

  // UART side: owns both FIFOs
  modport slave (
    output rx_empty,
    output read_data,
    output tx_full,
    input  read_uart,
    input  write_uart,
    input  write_data
  );
endinterface

// File: rtl/uart_led_cmd.sv
// rtl/uart_led_cmd.sv - two-byte UART command parser driving an LED register (optional timeout: UART_LED_CMD_TIMEOUT_EN)
module uart_led_cmd #(
  parameter int DBITS    = 8,
  parameter int LED_BITS = 8,
  parameter int TIMEOUT  = 1_000_000
) (
  input  logic                clk_50Mhz,
  input  logic                rst,
  uart_led_cmd_if.master      bus,
  output logic [LED_BITS-1:0] led,
  output logic                frame_err
);

  if (DBITS != 8 || LED_BITS < 1 || LED_BITS > DBITS || TIMEOUT < 2) begin : g_bad_params
    $error("uart_led_cmd: illegal parameter combination");
  end

  localparam logic [7:0] OP_SET    = 8'h53;
  localparam logic [7:0] OP_TOGGLE = 8'h54;
  localparam logic [7:0] OP_READ   = 8'h52;
  localparam logic [7:0] RESP_ACK  = 8'h06;
  localparam logic [7:0] RESP_NAK  = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP1,
    S_WAIT_ARG,
    S_GAP2,
    S_EXEC,
    S_RESP
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DBITS-1:0]   r_op;
  logic [DBITS-1:0]   r_arg;
  logic [DBITS-1:0]   r_resp;
  logic               w_pop;
  logic               w_push;
  logic               w_cap_op;
  logic               w_cap_arg;
  logic               w_exec;
  logic               w_cnt_clr;
  logic               w_cnt_inc;
  logic               w_abort;

`ifdef UART_LED_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          w_expired;
  assign w_expired = (r_cnt >= CW'(TIMEOUT - 1));
`endif

  // State register
  always_ff @(posedge clk_50Mhz or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state strobes; pops/pushes only when the FIFO flag allows
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_push      = 1'b0;
    w_cap_op    = 1'b0;
    w_cap_arg   = 1'b0;
    w_exec      = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.rx_empty) begin
          w_pop       = 1'b1;
          w_cap_op    = 1'b1;
          w_state_nxt = S_GAP1;
        end
      end
      S_GAP1: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = S_WAIT_ARG;
      end
      S_WAIT_ARG: begin
        if (!bus.rx_empty) begin
          // An arriving byte beats a simultaneous timeout
          w_pop       = 1'b1;
          w_cap_arg   = 1'b1;
          w_state_nxt = S_GAP2;
`ifdef UART_LED_CMD_TIMEOUT_EN
        end else if (w_expired) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
`endif
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_GAP2: begin
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_exec      = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (!bus.tx_full) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered FIFO strobes, captured bytes, LED register and response byte
  always_ff @(posedge clk_50Mhz or negedge rst) begin
    if (!rst) begin
      bus.read_uart  <= 1'b0;
      bus.write_uart <= 1'b0;
      bus.write_data <= '0;
      led            <= '0;
      r_op           <= '0;
      r_arg          <= '0;
      r_resp         <= '0;
    end else begin
      bus.read_uart  <= w_pop;
      bus.write_uart <= w_push;
      if (w_push) begin
        bus.write_data <= r_resp;
      end
      if (w_cap_op) begin
        r_op <= bus.read_data;
      end
      if (w_cap_arg) begin
        r_arg <= bus.read_data;
      end
      if (w_exec) begin
        case (r_op[7:0])
          OP_SET: begin
            led    <= r_arg[LED_BITS-1:0];
            r_resp <= DBITS'(RESP_ACK);
          end
          OP_TOGGLE: begin
            led    <= led ^ r_arg[LED_BITS-1:0];
            r_resp <= DBITS'(RESP_ACK);
          end
          OP_READ: begin
            r_resp <= DBITS'(led);
          end
          default: begin
            r_resp <= DBITS'(RESP_NAK);
          end
        endcase
      end
    end
  end

`ifdef UART_LED_CMD_TIMEOUT_EN
  // Argument-wait counter and the one-cycle abort pulse
  always_ff @(posedge clk_50Mhz or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= w_abort;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
`else
  logic w_unused_cnt;
  assign w_unused_cnt = w_cnt_clr ^ w_cnt_inc ^ w_abort;
  assign frame_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_led_cmd.sv
// tb/tb_uart_led_cmd.sv - directed self-checking bench for uart_led_cmd
module tb_uart_led_cmd;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] led;
  logic       frame_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_mem [0:63];
  int         rx_wr = 0;
  int         rx_rd = 0;
  int         pop_cnt = 0;
  int         pop_empty = 0;
  logic [7:0] tx_log [0:63];
  int         tx_cnt = 0;
  int         push_full = 0;
  int         fe_cnt = 0;

  always #5 clk = ~clk;

  uart_led_cmd_if #(.DBITS(8)) bus ();

  uart_led_cmd #(
    .DBITS    (8),
    .LED_BITS (8),
    .TIMEOUT  (20)
  ) dut (
    .clk_50Mhz (clk),
    .rst       (rst),
    .bus       (bus),
    .led       (led),
    .frame_err (frame_err)
  );

  assign bus.rx_empty  = (rx_rd == rx_wr);
  assign bus.read_data = rx_mem[rx_rd[5:0]];

  always @(posedge clk) begin
    if (bus.read_uart) begin
      pop_cnt <= pop_cnt + 1;
      if (rx_rd == rx_wr) pop_empty <= pop_empty + 1;
      else rx_rd <= rx_rd + 1;
    end
    if (bus.write_uart) begin
      tx_log[tx_cnt[5:0]] <= bus.write_data;
      tx_cnt <= tx_cnt + 1;
      if (bus.tx_full) push_full <= push_full + 1;
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_mem[rx_wr[5:0]] = b;
    rx_wr = rx_wr + 1;
  endtask

  task automatic wait_tx(input int target, input int budget);
    int n = 0;
    while (tx_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("tx_wait", tx_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] mask;
    int         lat;
    int         n;
    int         fe0;
    int         tx_base;

    rst = 1'b0;
    bus.tx_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_read_uart", bus.read_uart, 0);
    check("rst_write_uart", bus.write_uart, 0);
    check("rst_write_data", bus.write_data, 0);
    check("rst_led", led, 0);
    check("rst_frame_err", frame_err, 0);
    rst = 1'b1;
    @(negedge clk);

    // 'S' frame with both bytes queued: pops in cycles 1 and 3, push in cycle 6
    rx_push(8'h53);
    rx_push(8'hA5);
    mask = '0;
    lat  = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.read_uart) mask[k-1] = 1'b1;
      if (bus.write_uart && lat == 0) lat = k;
    end
    check("s_pop_cycles", mask, 10'h005);
    check("s_push_latency", lat, 6);
    check("s_tx_count", tx_cnt, 1);
    check("s_resp", tx_log[0], 8'h06);
    check("s_led", led, 8'hA5);
    check("s_pops", pop_cnt, 2);
    check("s_write_data_hold", bus.write_data, 8'h06);

    // Toggle
    rx_push(8'h54);
    rx_push(8'h0F);
    wait_tx(2, 40);
    check("t_led", led, 8'hAA);
    check("t_resp", tx_log[1], 8'h06);

    // Read back
    rx_push(8'h52);
    rx_push(8'h00);
    wait_tx(3, 40);
    check("r_led", led, 8'hAA);
    check("r_resp", tx_log[2], 8'hAA);

    // Unknown opcode
    rx_push(8'h41);
    rx_push(8'h12);
    wait_tx(4, 40);
    check("nak_resp", tx_log[3], 8'h15);
    check("nak_led", led, 8'hAA);
    check("nak_pops", pop_cnt, 8);

    // TX full for 100 cycles with a second frame already queued
    bus.tx_full = 1'b1;
    rx_push(8'h53);
    rx_push(8'h5A);
    rx_push(8'h54);
    rx_push(8'hFF);
    repeat (100) @(negedge clk);
    check("full_no_push", tx_cnt, 4);
    check("full_led_updated", led, 8'h5A);
    check("full_next_not_popped", pop_cnt, 10);
    check("full_write_uart_low", bus.write_uart, 0);
    bus.tx_full = 1'b0;
    @(negedge clk);
    check("release_push", bus.write_uart, 1);
    check("release_data", bus.write_data, 8'h06);
    wait_tx(6, 40);
    check("queued_led", led, 8'hA5);
    check("queued_resp0", tx_log[4], 8'h06);
    check("queued_resp1", tx_log[5], 8'h06);
    check("queued_pops", pop_cnt, 12);
    tx_base = 6;

`ifdef UART_LED_CMD_TIMEOUT_EN
    // Opcode alone: abort after the argument wait expires
    fe0 = fe_cnt;
    rx_push(8'h53);
    n = 0;
    while (!frame_err && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("to_latency_window", (n >= 18 && n <= 26), 1);
    repeat (3) @(negedge clk);
    check("to_single_pulse", fe_cnt - fe0, 1);
    check("to_no_push", tx_cnt, 6);
    rx_push(8'h53);
    rx_push(8'h3C);
    wait_tx(7, 40);
    check("to_recover_led", led, 8'h3C);
    check("to_recover_resp", tx_log[6], 8'h06);
    tx_base = 7;
`else
    fe0 = 0;
    n   = 0;
    check("no_frame_err", fe_cnt, 0);
`endif

    // Reset between the two bytes of an 'S' frame
    rx_push(8'h53);
    rx_push(8'hA5);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_led", led, 0);
    check("midrst_write_data", bus.write_data, 0);
    check("midrst_read_uart", bus.read_uart, 0);
    check("midrst_write_uart", bus.write_uart, 0);
    check("midrst_frame_err", frame_err, 0);
    @(negedge clk);
    rst = 1'b1;
    rx_push(8'h00);
    wait_tx(tx_base + 1, 40);
    check("midrst_leftover_nak", tx_log[tx_base[5:0]], 8'h15);
    check("midrst_led_after", led, 0);

    check("pop_while_empty", pop_empty, 0);
    check("push_while_full", push_full, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
